mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences a single shared 32-bit memory port between two requesters: A (instruction fetch) and B (load/store).
- Drives the select of the 32-bit 2x1 datapath multiplexer that steers requester addresses onto the port.
- Registers the granted address and holds it stable for the whole transaction.
- Handles a multi-cycle memory handshake, with a watchdog timeout for a memory that never answers.

Parameters:
- AW, 32, address width in bits (mux data width).
- TIMEOUT, 16, maximum cycles spent in a BUSY state waiting for mem_ready before abort; legal range 2..255.
- CW, 8, width of the internal watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A wants the port.
- addr_a  input  AW  requester A address.
- req_b  input  1  requester B wants the port.
- addr_b  input  AW  requester B address.
- mem_ready  input  1  memory completes the current access this cycle.
- sel  output  1  mux select: 0 = A path, 1 = B path.
- mem_req  output  1  access in progress toward memory.
- mem_addr  output  AW  registered address of the current access.
- done_a  output  1  one-cycle pulse: A's access finished.
- done_b  output  1  one-cycle pulse: B's access finished.
- err  output  1  one-cycle pulse: current access aborted by timeout.
- busy  output  1  high in any BUSY state.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. All outputs reset to 0, including sel. The state resets to IDLE and the watchdog counter to 0.
- States: IDLE, BUSY_A, BUSY_B. Encoding is free.
- IDLE transitions:
  - req_a only -> BUSY_A.
  - req_b only -> BUSY_B.
  - Both requesting -> resolved by the priority rule (see Optional Feature).
  - No request -> stay in IDLE.
- Grant edge: on the transition out of IDLE, sel, mem_addr and mem_req all register on the same clock edge.
  - sel <= granted side.
  - mem_addr <= granted address (addr_a or addr_b, sampled that cycle).
  - mem_req <= 1.
  - Latency from req to mem_req is 1 cycle.
- BUSY_x:
  - mem_req = 1, busy = 1; mem_addr and sel are held constant.
  - Requester address changes are ignored while BUSY.
- Completion: mem_ready = 1 in BUSY_x ->
  - done_x pulses high for exactly the next cycle.
  - mem_req <= 0; state -> IDLE; counter cleared.
- mem_ready while IDLE is ignored; no pulse is generated.
- IDLE always lasts at least one cycle between transactions. Back-to-back accesses by one requester therefore occur every (memory latency + 2) cycles at minimum.
- Requesters hold req until done or err. Dropping req mid-transaction does not cancel it; the access completes or times out normally.
- Watchdog:
  - The counter increments each BUSY cycle without mem_ready.
  - When the counter equals TIMEOUT-1 and mem_ready = 0: err pulses one cycle, no done pulse, mem_req <= 0, state -> IDLE, counter cleared.
  - If mem_ready and the timeout coincide in the same cycle, mem_ready wins: done pulses and err stays 0.
- In IDLE, sel keeps its last granted value (no glitching toward A), and mem_addr keeps its last value.
- Reset mid-transaction aborts immediately. No done or err is emitted, and the arbiter restarts in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Without it: fixed priority. B wins when both req_a and req_b are high in IDLE, which lets data accesses stall fetch.
- With it: round-robin.
  - A last-winner flag resets to A, so B wins the first tie.
  - On a tie, the side that did not win the previous grant wins.
  - The flag updates on every grant, including grants with no contention.
  - A timed-out grant still counts as that side's turn.

Test Plan:
- Single A access: req_a = 1, addr_a = 0x01001001, mem_ready asserted 3 cycles after mem_req rises -> sel = 0, mem_addr = 0x01001001 one cycle after req, done_a one-cycle pulse, then mem_req = 0, busy = 0.
- Contention, fixed priority: req_a = req_b = 1, addr_b = 0x00000000, mem_ready 1 cycle after grant, repeated -> B is granted first (sel = 1). A is granted only after req_b drops.
- Contention, ARB_ROUND_ROBIN_EN: both held high for 4 transactions -> grant order B, A, B, A; sel toggles 1, 0, 1, 0; done_b/done_a alternate.
- Timeout: req_b = 1, mem_ready never asserted, TIMEOUT = 16 -> mem_req is high for exactly 16 cycles, then err pulses once with no done_b and the state returns to IDLE. Also drive mem_ready in exactly the 16th cycle -> done_b and no err.
- Address stability: change addr_a every cycle during BUSY_A -> mem_addr holds the grant-cycle value. Drop req_a mid-access -> done_a is still emitted.
- Async reset: assert rst_n = 0 between clock edges during BUSY_B -> all outputs are 0 immediately, with no done_b. Release with req_a = 1 -> a normal A grant follows one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (A) and load/store (B), with a watchdog for a silent memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking. Without it, B wins a tie (fixed priority).
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic          mem_ready,
    output logic          sel,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          done_a,
    output logic          done_b,
    output logic          err,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

    state_t        state, stateNext;
    logic [CW-1:0] wdCount, wdCountNext;
    logic [AW-1:0] memAddrNext;
    logic          selNext, memReqNext, doneANext, doneBNext, errNext;
    logic          tieWinsB, grantB;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastWinnerB;

    // Every grant updates the flag, whether or not there was contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lastWinnerB <= 1'b0;
        else if (state == IDLE && (req_a || req_b))
            lastWinnerB <= grantB;
    end

    assign tieWinsB = ~lastWinnerB;
`else
    assign tieWinsB = 1'b1;
`endif

    assign grantB = req_b & (~req_a | tieWinsB);
    assign busy   = (state != IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        stateNext   = state;
        wdCountNext = wdCount;
        selNext     = sel;
        memAddrNext = mem_addr;
        memReqNext  = mem_req;
        doneANext   = 1'b0;
        doneBNext   = 1'b0;
        errNext     = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    stateNext   = grantB ? BUSY_B : BUSY_A;
                    selNext     = grantB;
                    memAddrNext = grantB ? addr_b : addr_a;
                    memReqNext  = 1'b1;
                    wdCountNext = '0;
                end
            end
            BUSY_A, BUSY_B: begin
                // mem_ready takes priority over a timeout that falls in the same cycle.
                if (mem_ready) begin
                    doneANext   = (state == BUSY_A);
                    doneBNext   = (state == BUSY_B);
                    stateNext   = IDLE;
                    memReqNext  = 1'b0;
                    wdCountNext = '0;
                end else if (wdCount == WD_LIMIT) begin
                    errNext     = 1'b1;
                    stateNext   = IDLE;
                    memReqNext  = 1'b0;
                    wdCountNext = '0;
                end else begin
                    wdCountNext = wdCount + CW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wdCount  <= '0;
            sel      <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            wdCount  <= wdCountNext;
            sel      <= selNext;
            mem_req  <= memReqNext;
            mem_addr <= memAddrNext;
            done_a   <= doneANext;
            done_b   <= doneBNext;
            err      <= errNext;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized traffic.
// All outputs are compared against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW      = 32;
    localparam int TIMEOUT = 16;
    localparam int CW      = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic          sel, mem_req, done_a, done_b, err, busy;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int passes = 0;
    int memReqHigh = 0, errCount = 0, doneBCount = 0;

    // Transaction-level model: owner 0 = none, 1 = A, 2 = B; age = busy cycles elapsed.
    int            owner = 0;
    int            age = 0;
    logic          mSel = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic          mDoneA = 1'b0, mDoneB = 1'b0, mErr = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    logic          lastB = 1'b0;
`endif

    mem_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
        .mem_ready(mem_ready),
        .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr),
        .done_a(done_a), .done_b(done_b), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic modelReset();
        owner = 0; age = 0; mSel = 1'b0; mAddr = '0;
        mDoneA = 1'b0; mDoneB = 1'b0; mErr = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        lastB = 1'b0;
`endif
    endtask

    task automatic modelEdge();
        logic pickB;
        mDoneA = 1'b0; mDoneB = 1'b0; mErr = 1'b0;
        if (owner == 0) begin
            if (req_a || req_b) begin
`ifdef ARB_ROUND_ROBIN_EN
                pickB = req_b && (!req_a || !lastB);
                lastB = pickB;
`else
                pickB = req_b;
`endif
                owner = pickB ? 2 : 1;
                mSel  = pickB;
                mAddr = pickB ? addr_b : addr_a;
                age   = 0;
            end
        end else begin
            age++;
            if (mem_ready) begin
                if (owner == 1) mDoneA = 1'b1; else mDoneB = 1'b1;
                owner = 0;
            end else if (age == TIMEOUT) begin
                mErr  = 1'b1;
                owner = 0;
            end
        end
    endtask

    task automatic checkOutputs();
        check("sel", sel, mSel);
        check("mem_req", mem_req, owner != 0);
        check("busy", busy, owner != 0);
        check("mem_addr", mem_addr, mAddr);
        check("done_a", done_a, mDoneA);
        check("done_b", done_b, mDoneB);
        check("err", err, mErr);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs();
        if (mem_req) memReqHigh++;
        if (err) errCount++;
        if (done_b) doneBCount++;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_outs"}, {sel, mem_req, busy, done_a, done_b, err}, 6'b0);
        check({tag, "_addr"}, mem_addr, '0);
    endtask

    initial begin
        logic expSel [4];
        logic lowReady;
`ifdef ARB_ROUND_ROBIN_EN
        expSel = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        expSel = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        #2 rst_n = 1'b0;
        #10 checkAllZero("reset");
        @(negedge clk) rst_n = 1'b1;
        modelReset();

        // Single A access; the address changes every busy cycle and must not disturb mem_addr.
        req_a = 1'b1; addr_a = 32'h01001001;
        cycle();
        check("t1_sel", sel, 1'b0);
        check("t1_addr", mem_addr, 32'h01001001);
        for (int i = 0; i < 2; i++) begin
            addr_a = $urandom;
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        check("t1_done_a", done_a, 1'b1);
        req_a = 1'b0; mem_ready = 1'b0;
        cycle();
        check("t1_idle", {mem_req, busy}, 2'b00);

        // Contention: both requesters hold for four transactions, then B drops out.
        req_a = 1'b1; req_b = 1'b1; addr_a = $urandom; addr_b = 32'h0;
        for (int t = 0; t < 4; t++) begin
            cycle();
            check($sformatf("t2_grant%0d_sel", t), sel, expSel[t]);
            mem_ready = 1'b1;
            cycle();
            mem_ready = 1'b0;
        end
        req_b = 1'b0;
        cycle();
        check("t2_a_after_b_drops", sel, 1'b0);
        mem_ready = 1'b1; req_a = 1'b0;
        cycle();
        check("t2_done_a_dropped_req", done_a, 1'b1);
        mem_ready = 1'b0;
        cycle();

        // Timeout: B is granted and mem_ready never arrives.
        memReqHigh = 0; errCount = 0; doneBCount = 0;
        req_b = 1'b1;
        for (int i = 0; i < TIMEOUT + 1; i++) cycle();
        check("t3_memreq_cycles", memReqHigh, TIMEOUT);
        check("t3_err_count", errCount, 1);
        check("t3_no_done_b", doneBCount, 0);
        req_b = 1'b0;
        cycle();

        // mem_ready arrives in the last cycle before the timeout, so it must win.
        req_b = 1'b1;
        cycle();
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        mem_ready = 1'b1;
        cycle();
        check("t3_coincide_done_b", done_b, 1'b1);
        check("t3_coincide_err", err, 1'b0);
        mem_ready = 1'b0; req_b = 1'b0;
        cycle();

        // Asynchronous reset during BUSY_B.
        req_b = 1'b1; addr_b = $urandom;
        cycle();
        cycle();
        #3 rst_n = 1'b0;
        #1 checkAllZero("t4_async");
        modelReset();
        req_b = 1'b0; req_a = 1'b1; addr_a = $urandom;
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check("t4_regrant_sel", sel, 1'b0);
        check("t4_regrant_req", mem_req, 1'b1);
        req_a = 1'b0; mem_ready = 1'b1;
        cycle();
        mem_ready = 1'b0;

        // Randomized traffic with phases of slow memory and occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            lowReady = ((c / 500) % 2) == 1;
            req_a     = ($urandom_range(0, 9) < 6);
            req_b     = ($urandom_range(0, 9) < 6);
            addr_a    = $urandom;
            addr_b    = $urandom;
            mem_ready = lowReady ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 2) == 0);
            cycle();
            if ($urandom_range(0, 499) == 0) begin
                #3 rst_n = 1'b0;
                #1 checkAllZero("rand_async");
                modelReset();
                @(negedge clk) rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
